// File: rtl/risc5_mem_pkg.sv
// risc5_mem_pkg: shared types and constants for the RISC5 SRAM bridge.
package risc5_mem_pkg;

  localparam int WAIT_MAX = 15;
  localparam int WCNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } kind_t;

  // Active-low byte enables for a byte write; lane0 picks dq[15:8] when set.
  function automatic logic [1:0] byte_be_n(input logic lane0);
    return lane0 ? 2'b01 : 2'b10;
  endfunction

endpackage

// File: rtl/sram_phase_timer.sv
// sram_phase_timer: loadable down-counter; last is high on the final cycle
// of an SRAM phase (count == 0).
module sram_phase_timer
  import risc5_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WCNT_W-1:0] init,
  output logic              last
);

  logic [WCNT_W-1:0] cnt;

  // Reload on phase entry, otherwise count down and park at zero
  always_ff @(posedge clk) begin
    if (rst)             cnt <= '0;
    else if (load)       cnt <= init;
    else if (cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign last = (cnt == '0);

endmodule

// File: rtl/risc5_sram_bridge.sv
// risc5_sram_bridge: RISC5 memory-port responder on a 16-bit async SRAM.
// Each access runs as one or two halfword phases of WAIT+1 cycles.
// Optional build macro RISC5_FETCH_BUF_EN adds a one-word fetch buffer.
module risc5_sram_bridge
  import risc5_mem_pkg::*;
#(
  parameter int WAIT  = 1,
  parameter int ADR_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [23:0]      adr,
  input  logic             rd,
  input  logic             wr,
  input  logic             ben,
  input  logic [31:0]      outbus,
  output logic [31:0]      inbus,
  output logic [31:0]      codebus,
  output logic             stallX,
  output logic [ADR_W-1:0] sram_adr,
  output logic [15:0]      sram_dq_o,
  input  logic [15:0]      sram_dq_i,
  output logic             sram_dq_oe,
  output logic             sram_ce_n,
  output logic             sram_oe_n,
  output logic             sram_we_n,
  output logic [1:0]       sram_be_n
);

  localparam int WORD_W = ADR_W - 1;
  localparam logic [WCNT_W-1:0] WAIT_CNT =
    (WAIT > WAIT_MAX) ? WCNT_W'(WAIT_MAX) : WCNT_W'(WAIT);

  state_t            state_q, state_d;
  kind_t             kind_q, kind_a, kind_c;
  logic [WORD_W-1:0] word_q, word_a, word_c;
  logic [1:0]        lane_q;
  logic              byte_q, byte_a;
  logic [31:0]       wdata_q, wdata_c, data_q;
  logic              stall_q, last, phase_load, in_phase, hit;
  logic [31:0]       hit_data;
  logic [ADR_W-1:0]  sadr_q;
  logic [15:0]       dq_o_q;

  // Address bits above the SRAM range are dropped, so accesses wrap.
  logic unused_adr;
  assign unused_adr = ^adr[23:ADR_W+1];

  // Request decode: a store wins over a load, nothing asserted means fetch
  always_comb begin
    kind_a = FETCH;
    if (wr)      kind_a = WRITE;
    else if (rd) kind_a = READ;
  end

  assign byte_a = ben & (rd | wr);
  assign word_a = adr[ADR_W:2];

  // Values for the phase being entered: live inputs on accept, else captured.
  assign kind_c  = (state_q == IDLE) ? kind_a : kind_q;
  assign word_c  = (state_q == IDLE) ? word_a : word_q;
  assign wdata_c = (state_q == IDLE) ? outbus : wdata_q;

`ifdef RISC5_FETCH_BUF_EN
  logic              buf_vld;
  logic [WORD_W-1:0] buf_tag;
  logic [31:0]       buf_data;

  assign hit      = (state_q == IDLE) && (kind_a == FETCH) && buf_vld && (buf_tag == word_a);
  assign hit_data = buf_data;

  // Fetch buffer: stores kill a matching entry at accept, fetches refill in DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_vld  <= 1'b0;
      buf_tag  <= '0;
      buf_data <= '0;
    end else if ((state_q == IDLE) && (kind_a == WRITE) && (buf_tag == word_a)) begin
      buf_vld <= 1'b0;
    end else if ((state_q == DONE) && (kind_q == FETCH)) begin
      buf_vld  <= 1'b1;
      buf_tag  <= word_q;
      buf_data <= data_q;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  // Next-state: word = LO,HI; byte picks the half holding its lane
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (hit)                     state_d = DONE;
        else if (!byte_a || !adr[1]) state_d = LO;
        else                         state_d = HI;
      end
      LO:      if (last) state_d = byte_q ? DONE : HI;
      HI:      if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign phase_load = ((state_d == LO) || (state_d == HI)) && (state_d != state_q);
  assign in_phase   = (state_q == LO) || (state_q == HI);

  sram_phase_timer u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (phase_load),
    .init (WAIT_CNT),
    .last (last)
  );

  // State, registered stall and request capture at accept
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      stall_q <= 1'b0;
      kind_q  <= FETCH;
      word_q  <= '0;
      lane_q  <= '0;
      byte_q  <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= (state_d == LO) || (state_d == HI);
      if (state_q == IDLE) begin
        kind_q  <= kind_a;
        word_q  <= word_a;
        lane_q  <= adr[1:0];
        byte_q  <= byte_a;
        wdata_q <= outbus;
      end
    end
  end

  // SRAM address and write data are latched at each phase entry and held
  always_ff @(posedge clk) begin
    if (rst) begin
      sadr_q <= '0;
      dq_o_q <= '0;
    end else if (phase_load) begin
      sadr_q <= {word_c, (state_d == HI)};
      if (kind_c == WRITE)
        dq_o_q <= (state_d == HI) ? wdata_c[31:16] : wdata_c[15:0];
    end
  end

  // Read data assembly; byte reads still take the whole halfword
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else if (hit) begin
      data_q <= hit_data;
    end else if (last && (kind_q != WRITE)) begin
      if (state_q == LO) data_q[15:0]  <= sram_dq_i;
      if (state_q == HI) data_q[31:16] <= sram_dq_i;
    end
  end

  // Strobes decoded from state; we_n releases on the last cycle for data hold
  always_comb begin
    sram_ce_n  = 1'b1;
    sram_oe_n  = 1'b1;
    sram_we_n  = 1'b1;
    sram_be_n  = 2'b11;
    sram_dq_oe = 1'b0;
    if (in_phase) begin
      sram_ce_n = 1'b0;
      if (kind_q == WRITE) begin
        sram_dq_oe = 1'b1;
        sram_we_n  = last && (WAIT_CNT != '0);
        sram_be_n  = byte_q ? byte_be_n(lane_q[0]) : 2'b00;
      end else begin
        sram_oe_n = 1'b0;
        sram_be_n = 2'b00;
      end
    end
  end

  assign sram_adr  = sadr_q;
  assign sram_dq_o = dq_o_q;
  assign stallX    = stall_q;
  assign inbus     = data_q;
  assign codebus   = data_q;

endmodule

// File: tb/tb_risc5_sram_bridge.sv
// tb_risc5_sram_bridge: directed + random transactions against a
// transaction-level model of the bridge and a behavioural SRAM.
module tb_risc5_sram_bridge;

  localparam int TB_WAIT = 1;
  localparam int ADR_W   = 20;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [23:0]      adr = '0;
  logic             rd = 1'b0, wr = 1'b0, ben = 1'b0;
  logic [31:0]      outbus = '0;
  logic [31:0]      inbus, codebus;
  logic             stallX;
  logic [ADR_W-1:0] sram_adr;
  logic [15:0]      sram_dq_o, sram_dq_i;
  logic             sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
  logic [1:0]       sram_be_n;

  logic [15:0] env_mem [256];   // the SRAM chip
  logic [15:0] mm      [256];   // model's view of memory
  logic [31:0] mdata = '0;      // model's last load data
`ifdef RISC5_FETCH_BUF_EN
  bit          fb_v = 1'b0;
  int          fb_tag = 0;
  logic [31:0] fb_data = '0;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? env_mem[sram_adr[7:0]] : 16'hBAD0;

  risc5_sram_bridge #(.WAIT(TB_WAIT), .ADR_W(ADR_W)) dut (
    .clk(clk), .rst(rst), .adr(adr), .rd(rd), .wr(wr), .ben(ben),
    .outbus(outbus), .inbus(inbus), .codebus(codebus), .stallX(stallX),
    .sram_adr(sram_adr), .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i),
    .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // k: 0 fetch, 1 read, 2 write, 3 rd+wr together. Entered at the negedge of a
  // DONE cycle (or, with from_reset, of a reset cycle); returns at DONE.
  task automatic run_op(input int k, input logic [23:0] a, input logic b,
                        input logic [31:0] ob, input bit from_reset,
                        output logic [31:0] got);
    bit          is_w, is_f, byt, hit;
    int          wordi, n, lat, np, pi, kp, hw;
    int          ph [2];
    logic [31:0] exp;
    logic [1:0]  exp_be;
    is_w  = (k >= 2);
    is_f  = (k == 0);
    byt   = b && !is_f;
    wordi = int'(a >> 2) & 32'h7FFFF;
    np    = byt ? 1 : 2;
    ph[0] = byt ? int'(a[1]) : 0;
    ph[1] = 1;
    hit   = 1'b0;
`ifdef RISC5_FETCH_BUF_EN
    hit = is_f && fb_v && (fb_tag == wordi);
    if (is_w && fb_tag == wordi) fb_v = 1'b0;
`endif
    if (hit) np = 0;
    n      = TB_WAIT + 1;
    lat    = np * n + 1;
    exp_be = (is_w && byt) ? (a[0] ? 2'b01 : 2'b10) : 2'b00;
    exp    = mdata;
`ifdef RISC5_FETCH_BUF_EN
    if (hit) exp = fb_data;
`endif
    if (!is_w && !hit)
      for (int p = 0; p < np; p++) exp[ph[p]*16 +: 16] = mm[(wordi*2 + ph[p]) & 255];

    wr = is_w; rd = (k == 1 || k == 3); adr = a; ben = b; outbus = ob;
    if (from_reset) rst = 1'b0;
    else begin
      @(negedge clk);
      chk("idle_stall", stallX, 0);
      chk("idle_ce_n", sram_ce_n, 1);
    end

    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (!sram_ce_n && !sram_we_n) begin
        if (!sram_be_n[0]) env_mem[sram_adr[7:0]][7:0]  = sram_dq_o[7:0];
        if (!sram_be_n[1]) env_mem[sram_adr[7:0]][15:8] = sram_dq_o[15:8];
      end
      if (c == 1) begin  // junk on the request pins; must be ignored
        adr = 24'($urandom); wr = 1'($urandom); rd = 1'($urandom);
        ben = 1'($urandom); outbus = $urandom;
      end
      if (c < lat) begin
        pi = (c - 1) / n;
        kp = (c - 1) % n;
        chk("ph_stall", stallX, 1);
        chk("ph_ce_n", sram_ce_n, 0);
        chk("ph_adr", sram_adr, 64'(wordi*2 + ph[pi]));
        chk("ph_oe_n", sram_oe_n, is_w);
        chk("ph_we_n", sram_we_n, is_w ? !(n == 1 || kp < n - 1) : 1'b1);
        chk("ph_be_n", sram_be_n, exp_be);
        chk("ph_dq_oe", sram_dq_oe, is_w);
        if (is_w) chk("ph_dq_o", sram_dq_o, ob[ph[pi]*16 +: 16]);
      end else begin
        chk("done_stall", stallX, 0);
        chk("done_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_be_n, sram_dq_oe}, 6'b111110);
        chk("done_inbus", inbus, exp);
        chk("done_codebus", codebus, exp);
      end
    end
    got = inbus;

    if (!is_w) mdata = exp;
    if (is_w) begin
      for (int p = 0; p < np; p++) begin
        hw = (wordi*2 + ph[p]) & 255;
        if (!byt) mm[hw] = ob[ph[p]*16 +: 16];
        else      mm[hw][int'(a[0])*8 +: 8] = ob[int'(a[1:0])*8 +: 8];
        chk("mem_after_wr", env_mem[hw], mm[hw]);
      end
    end
`ifdef RISC5_FETCH_BUF_EN
    if (is_f) begin fb_v = 1'b1; fb_tag = wordi; fb_data = exp; end
`endif
  endtask

  initial begin
    logic [31:0] got;
    logic [23:0] ra;
    for (int i = 0; i < 256; i++) begin
      env_mem[i] = 16'($urandom);
      mm[i] = env_mem[i];
    end
    env_mem[8'h82] = 16'h5678; mm[8'h82] = 16'h5678;
    env_mem[8'h83] = 16'h1234; mm[8'h83] = 16'h1234;
    env_mem[8'h03] = 16'h1122; mm[8'h03] = 16'h1122;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_stall", stallX, 0);
    chk("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_be_n, sram_dq_oe}, 6'b111110);
    chk("rst_dq_o", sram_dq_o, 0);
    chk("rst_adr", sram_adr, 0);
    chk("rst_inbus", inbus, 0);
    chk("rst_codebus", codebus, 0);

    // word read across halfwords 0x82/0x83
    run_op(1, 24'h000104, 1'b0, 32'h0, 1'b1, got);
    chk("word_read_val", got, 32'h12345678);

    // byte store to lane 3: HI phase only
    run_op(2, 24'h000007, 1'b1, 32'hAB000000, 1'b0, got);
    chk("byte_store_mem", env_mem[3], 16'hAB22);

    // word write then read back
    run_op(2, 24'h000000, 1'b0, 32'hDEADBEEF, 1'b0, got);
    run_op(1, 24'h000000, 1'b0, 32'h0, 1'b0, got);
    chk("wr_rd_back", got, 32'hDEADBEEF);

    // rd and wr together behave as a write
    run_op(3, 24'h000010, 1'b0, 32'hCAFE0123, 1'b0, got);

    // two fetches of one word, then store into it and fetch again
    run_op(0, 24'h000040, 1'b0, 32'h0, 1'b0, got);
    run_op(0, 24'h000040, 1'b0, 32'h0, 1'b0, got);
    run_op(2, 24'h000041, 1'b1, 32'h00005A00, 1'b0, got);
    run_op(0, 24'h000040, 1'b0, 32'h0, 1'b0, got);
    chk("fetch_after_store", got[15:8], 8'h5A);

    // random traffic; upper address bits exercise wrap
    for (int i = 0; i < 150; i++) begin
      ra = 24'($urandom) & 24'hE0003F;
      run_op(int'($urandom_range(0, 3)), ra, 1'($urandom), $urandom, 1'b0, got);
    end

    // reset during the HI phase of a word write
    rd = 1'b0; wr = 1'b1; ben = 1'b0; adr = 24'h0001F0; outbus = 32'h0BADF00D;
    @(negedge clk);
    repeat (TB_WAIT + 2) @(negedge clk);
    chk("abort_in_hi", {stallX, sram_we_n, sram_adr}, {1'b1, 1'b0, 20'hF9});
    rst = 1'b1;
    @(negedge clk);
    chk("abort_we_n", sram_we_n, 1);
    chk("abort_stall", stallX, 0);
    chk("abort_strobes", {sram_ce_n, sram_oe_n, sram_be_n, sram_dq_oe}, 5'b11110);
    chk("abort_inbus", inbus, 0);
    mdata = '0;
`ifdef RISC5_FETCH_BUF_EN
    fb_v = 1'b0;
`endif
    run_op(1, 24'h000008, 1'b0, 32'h0, 1'b1, got);
    for (int i = 0; i < 20; i++) begin
      ra = 24'($urandom) & 24'h00003F;
      run_op(int'($urandom_range(0, 3)), ra, 1'($urandom), $urandom, 1'b0, got);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/risc5_sram_bridge.md
# risc5_sram_bridge

Bus responder for the RISC5 processor's memory port. It accepts one instruction fetch, word load/store or byte load/store at a time on the processor side (adr, rd, wr, ben, outbus), and executes it on an external 16-bit asynchronous SRAM as one or two halfword phases with programmable wait states. It returns inbus/codebus and throttles the processor through stallX. It sits between the RISC5 core and the board SRAM pins.

## Interface
- WAIT, 1: extra cycles per SRAM halfword phase (0..15); one phase lasts WAIT+1 cycles.
- ADR_W, 20: SRAM halfword address width.
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- adr  in  24  byte address from processor.
- rd  in  1  data load request.
- wr  in  1  data store request; has priority over rd.
- ben  in  1  byte access qualifier for rd/wr.
- outbus  in  32  store data, already lane-positioned by the processor.
- inbus  out  32  load data, full word.
- codebus  out  32  fetch data, full word.
- stallX  out  1  responder busy; registered.
- sram_adr  out  ADR_W  halfword address.
- sram_dq_o  out  16  write data.
- sram_dq_i  in  16  read data.
- sram_dq_oe  out  1  pad output enable.
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  active-low strobes.
- sram_be_n  out  2  active-low byte enables; [0]=dq[7:0].

## Operation
- States: IDLE, LO, HI, DONE.
- IDLE accepts a request every cycle:
  - kind = WRITE if wr, READ if rd, else FETCH.
  - Captures word address adr[ADR_W:2], lane adr[1:0], ben and outbus.
- Phase selection:
  - Word access: LO then HI.
  - Byte access with lane[1]=0: LO only.
  - Byte access with lane[1]=1: HI only.
- LO drives sram_adr={word,0}; HI drives sram_adr={word,1}. Upper address bits beyond ADR_W+1 are ignored, so addresses wrap.
- Read/fetch phase:
  - ce_n=0, oe_n=0, dq_oe=0, be_n=00.
  - sram_dq_i is sampled on the phase's last cycle into data[15:0] (LO) or data[31:16] (HI).
  - Byte reads still load the whole halfword; the processor performs lane selection.
- Write phase:
  - ce_n=0, dq_oe=1, dq_o = the corresponding half of outbus.
  - we_n=0 on every phase cycle except the last, giving a data-hold cycle. With WAIT=0, we_n pulses for the single phase cycle.
  - be_n=00 for word writes; for byte writes only the lane[0]-selected byte is enabled.
- DONE, one cycle: all strobes inactive; inbus=codebus=data. Then return to IDLE.
- On writes, data is left unchanged.
- stallX=1 in LO and HI; 0 in IDLE and DONE.
- Request inputs are ignored outside IDLE.

## Timing
- Reset values: state IDLE, stallX 0, ce_n/oe_n/we_n 1, be_n 11, dq_oe 0, dq_o 0, sram_adr 0, data 0, inbus/codebus 0.
- Reset mid-operation aborts at that edge; we_n rises on the same edge, and the partial write is not retried.
- Latency from the accept cycle (cycle 0) to DONE:
  - Word: 2(WAIT+1)+1.
  - Byte: (WAIT+1)+1.
  - Example, WAIT=1: word DONE at cycle 5, byte DONE at cycle 3.
- The wait counter reloads to WAIT at each phase entry and counts down to 0, which marks the last phase cycle.
- Simultaneous rd and wr: treated as WRITE.

## Configuration
- RISC5_FETCH_BUF_EN defined:
  - A one-word fetch buffer holds a tag (word address), a valid bit and the data.
  - A FETCH that hits the tag goes IDLE→DONE directly (latency 1, no SRAM activity).
  - Every completed FETCH refills the buffer.
  - Any WRITE whose word address matches the tag clears valid at accept.
  - Reset clears valid.
- Undefined: every FETCH accesses SRAM.

## Structure
- Package risc5_mem_pkg holds:
  - State enum.
  - Access-kind enum (FETCH/READ/WRITE).
  - WAIT_MAX=15.
  - Wait-counter width of 4.
- One sub-module, sram_phase_timer: loadable down-counter with a last-cycle flag.

## Test plan
- Word read, WAIT=1, adr=0x000104, SRAM halfwords 0x82=0x5678 and 0x83=0x1234 -> stallX high cycles 1–4; DONE at cycle 5 with inbus=0x12345678 and sram_adr sequence 0x82, 0x83.
- Byte store, adr=0x000007, outbus=0xAB000000 -> HI phase only, sram_adr=0x03, be_n=01, we_n low for 1 cycle, DONE at cycle 3.
- WAIT=0 word write of 0xDEADBEEF to adr 0 -> we_n pulses in cycles 1 and 2; a subsequent read returns 0xDEADBEEF at cycle 3.
- rd=wr=1 at accept -> WRITE performed, no oe_n assertion.
- rst asserted during HI of a word write -> next edge gives we_n=1, stallX=0, state IDLE, all strobes inactive.
- With RISC5_FETCH_BUF_EN:
  - Two fetches of adr 0x40 -> second DONE in cycle 1 with no ce_n activity.
  - Store to adr 0x41, then fetch 0x40 -> SRAM access occurs.
